// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg: shared state encoding and default widths for the accumulator.
package sum_accumulator_pkg;
  localparam int ACC_W_DEF = 12;
  localparam int LEN_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/sum_accumulator_beat_counter.sv
// beat_counter: loadable run length and accepted-beat counter with terminal-count flag.
module beat_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             inc_i,
  output logic             tc_o
);
  logic [LEN_W:0] len_q, len_d, cnt_q, cnt_d;
  // One extra bit so a zero length can stand for a full 2^LEN_W beats.
  always_comb begin
    len_d = load_i ? ((len_i == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_i}) : len_q;
    cnt_d = load_i ? '0 : inc_i ? cnt_q + (LEN_W+1)'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  assign tc_o = (cnt_q + (LEN_W+1)'(1)) == len_q;
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums a fixed-length run of 9-bit adder results with sticky overflow.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       sum,
  input  logic             cout,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             load, accept, tc;
  logic [ACC_W:0]   add;
  assign load   = (state_q == IDLE) && start;
  assign accept = in_valid && in_ready;
  assign add    = {1'b0, acc_q} + {{(ACC_W-8){1'b0}}, cout, sum};
  beat_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .len_i  (len),
    .inc_i  (accept),
    .tc_o   (tc)
  );
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = ACCUM;
      end
      ACCUM: if (accept) begin
        acc_d   = add[ACC_W-1:0];
        ovf_d   = ovf_q | add[ACC_W];
        state_d = tc ? DONE : ACCUM;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  assign in_ready  = state_q == ACCUM;
  assign acc_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign acc       = acc_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed checks of run length, overflow, stalls, ignored controls and reset.
module tb_sum_accumulator;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0, cout = 0, out_ready = 0;
  logic [3:0]  len = 0;
  logic [7:0]  sum = 0;
  logic        in_ready, acc_valid, ovf, busy;
  logic [11:0] acc;
  int n_tests = 0, n_fail = 0;

  sum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .cout(cout), .acc(acc), .acc_valid(acc_valid),
    .out_ready(out_ready), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input logic v, input logic [7:0] s, input logic c);
    in_valid = v; sum = s; cout = c;
  endtask

  task automatic chk_out(input string tag, input logic [11:0] a, input logic o, input logic av,
                         input logic ir, input logic b);
    chk({tag, ".acc"}, acc, a);
    chk({tag, ".ovf"}, ovf, o);
    chk({tag, ".acc_valid"}, acc_valid, av);
    chk({tag, ".in_ready"}, in_ready, ir);
    chk({tag, ".busy"}, busy, b);
  endtask

  initial begin
    #1 chk_out("reset", 0, 0, 0, 0, 0);
    tick(); rst_n = 1;
    tick();
    chk_out("idle", 0, 0, 0, 0, 0);

    // len=3: 10 + 511 + 1 = 522, DONE on the 4th edge counting the start cycle
    start = 1; len = 3; beat(1, 8'd99, 0);
    tick(); start = 0;
    chk_out("r1.start", 0, 0, 0, 1, 1);
    beat(1, 10, 0); tick(); chk_out("r1.b1", 10, 0, 0, 1, 1);
    beat(1, 255, 1); tick(); chk_out("r1.b2", 521, 0, 0, 1, 1);
    beat(1, 1, 0); tick(); chk_out("r1.done", 522, 0, 1, 0, 1);
    beat(0, 0, 0); out_ready = 1;
    tick(); out_ready = 0;
    chk_out("r1.idle", 522, 0, 0, 0, 0);

    // len=0 means 16 beats of 511: 8176 wraps to 4080 with overflow
    start = 1; len = 0;
    tick(); start = 0;
    beat(1, 255, 1);
    for (int i = 0; i < 15; i++) tick();
    chk_out("r2.b15", 12'd3569, 1, 0, 1, 1);
    tick(); beat(0, 0, 0);
    chk_out("r2.done", 12'd4080, 1, 1, 0, 1);
    start = 1; len = 1; beat(1, 5, 0);
    tick(); start = 0; beat(0, 0, 0);
    chk_out("r2.start_in_done", 12'd4080, 1, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("r2.hold.acc", acc, 12'd4080);
      chk("r2.hold.ovf", ovf, 1);
      chk("r2.hold.acc_valid", acc_valid, 1);
    end
    out_ready = 1;
    tick(); out_ready = 0;
    chk_out("r2.idle", 12'd4080, 1, 0, 0, 0);

    // len=2 with a 5-cycle stall and a stray start in the gap: 100 + 456 = 556
    start = 1; len = 2;
    tick(); start = 0;
    chk_out("r3.start", 0, 0, 0, 1, 1);
    beat(1, 100, 0); tick(); beat(0, 0, 0);
    chk_out("r3.b1", 100, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 1;
      tick();
      chk("r3.gap.acc", acc, 100);
      chk("r3.gap.acc_valid", acc_valid, 0);
    end
    start = 0;
    beat(1, 200, 1); tick(); beat(0, 0, 0);
    chk_out("r3.done", 12'd556, 0, 1, 0, 1);
    out_ready = 1;
    tick(); out_ready = 0;

    // reset mid-run of len=4, then a clean len=1 run
    start = 1; len = 4;
    tick(); start = 0;
    beat(1, 1, 0); tick();
    beat(1, 2, 0); tick();
    chk_out("r4.b2", 3, 0, 0, 1, 1);
    beat(0, 0, 0);
    #2 rst_n = 0;
    #1 chk_out("r4.async_rst", 0, 0, 0, 0, 0);
    tick(); rst_n = 1;
    tick();
    chk_out("r4.after_rst", 0, 0, 0, 0, 0);
    start = 1; len = 1;
    tick(); start = 0;
    beat(1, 7, 0); tick(); beat(0, 0, 0);
    chk_out("r5.done", 7, 0, 1, 0, 1);
    out_ready = 1;
    tick(); out_ready = 0;
    chk_out("r5.idle", 7, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
